// File: rtl/periph_leds_ctrl.sv
// Memory-mapped LED controller: pattern, blink, rotate and PWM dimming.
// Single-cycle-ack register bus in front of a step prescaler and PWM stage.
module periph_leds_ctrl #(
    parameter int LED_WIDTH  = 9,
    parameter int DATA_WIDTH = 32,
    parameter int PERIOD_RST = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sel,
    input  logic                  we,
    input  logic [2:0]            addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ack,
    output logic [LED_WIDTH-1:0]  out
);

    typedef enum logic {
        IDLE,
        ACK
    } state_e;

    localparam logic [1:0]  MODE_BLINK = 2'd1;
    localparam logic [1:0]  MODE_ROTL  = 2'd2;
    localparam logic [1:0]  MODE_ROTR  = 2'd3;
    localparam logic [15:0] PER_RST    = 16'(PERIOD_RST);

    state_e                 state_q, state_d;
    logic [LED_WIDTH-1:0]   data_q, data_d;
    logic [1:0]             mode_q, mode_d;
    logic [15:0]            period_q, period_d;
    logic [7:0]             bright_q, bright_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   phase_q, phase_d;
    logic [7:0]             pwm_q, pwm_d;
    logic [LED_WIDTH-1:0]   out_q, out_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

    logic                   acc;
    logic                   wr_data, wr_mode, wr_period, wr_bright;
    logic                   step, restart, lit;
    logic [LED_WIDTH-1:0]   rot_l, rot_r, disp;
    logic [DATA_WIDTH-1:0]  rd_val;
    logic                   unused_wdata;

    assign unused_wdata = ^wdata[DATA_WIDTH-1:16];

    always_comb begin
        state_d = state_q;
        acc     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel) begin
                    acc     = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: state_d = IDLE;
        endcase
    end

    assign wr_data   = acc && we && (addr == 3'd0);
    assign wr_mode   = acc && we && (addr == 3'd1);
    assign wr_period = acc && we && (addr == 3'd2);
    assign wr_bright = acc && we && (addr == 3'd3);

    always_comb begin
        rd_val = '0;
        case (addr)
            3'd0: rd_val[LED_WIDTH-1:0] = data_q;
            3'd1: rd_val[1:0]           = mode_q;
            3'd2: rd_val[15:0]          = period_q;
            3'd3: rd_val[7:0]           = bright_q;
            3'd4: begin
                rd_val[0]    = phase_q;
                rd_val[23:8] = cnt_q;
            end
            default: rd_val = '0;
        endcase
    end

    assign step    = (cnt_q == period_q);
    assign restart = wr_mode || wr_period;
    assign rot_l   = {data_q[LED_WIDTH-2:0], data_q[LED_WIDTH-1]};
    assign rot_r   = {data_q[0], data_q[LED_WIDTH-1:1]};
    assign lit     = (bright_q == 8'hFF) || (pwm_q < bright_q);
    assign disp    = (mode_q == MODE_BLINK && !phase_q) ? '0 : data_q;

    always_comb begin
        data_d   = data_q;
        mode_d   = mode_q;
        period_d = period_q;
        bright_d = bright_q;
        // A CPU write to DATA overrides a coincident rotation
        if (wr_data)
            data_d = wdata[LED_WIDTH-1:0];
        else if (step && mode_q == MODE_ROTL)
            data_d = rot_l;
        else if (step && mode_q == MODE_ROTR)
            data_d = rot_r;
        if (wr_mode)
            mode_d = wdata[1:0];
        if (wr_period)
            period_d = wdata[15:0];
        if (wr_bright)
            bright_d = wdata[7:0];
        cnt_d = (restart || step) ? '0 : cnt_q + 16'd1;
        if (restart)
            phase_d = 1'b1;
        else if (step && mode_q == MODE_BLINK)
            phase_d = ~phase_q;
        else
            phase_d = phase_q;
        pwm_d   = pwm_q + 8'd1;
        out_d   = lit ? disp : '0;
        rdata_d = (acc && !we) ? rd_val : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            data_q   <= '0;
            mode_q   <= '0;
            period_q <= PER_RST;
            bright_q <= 8'hFF;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
            pwm_q    <= '0;
            out_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            bright_q <= bright_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            pwm_q    <= pwm_d;
            out_q    <= out_d;
            rdata_q  <= rdata_d;
        end
    end

    assign ack   = (state_q == ACK);
    assign rdata = rdata_q;
    assign out   = out_q;

endmodule

// File: doc/periph_leds_ctrl.md
# periph_leds_ctrl

Memory-mapped LED controller between the CPU data-memory bus and the 9-bit board LED pins. The CPU stores a pattern, mode, step period and brightness into four registers. The block produces the `out[8:0]` LED vector that `periph_leds` drives, with hardware blink, rotate and PWM dimming so firmware does not have to poll.

## Interface
- `LED_WIDTH`, 9, LED vector width.
- `DATA_WIDTH`, 32, bus data width.
- `PERIOD_RST`, 1000, reset value of the PERIOD register (clk cycles per step minus one).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `sel`  in  1  bus request; held high until `ack`.
- `we`  in  1  1 = write, 0 = read; valid while `sel`.
- `addr`  in  3  word offset of the register.
- `wdata`  in  DATA_WIDTH  write data.
- `rdata`  out  DATA_WIDTH  read data; valid only while `ack`, 0 otherwise.
- `ack`  out  1  one-cycle transfer completion pulse.
- `out`  out  LED_WIDTH  registered LED drive, 1 = lit.

## Operation
- **Register map** (`addr`):
  - 0 DATA[8:0]
  - 1 MODE[1:0]: 0 static, 1 blink, 2 rotate-left, 3 rotate-right
  - 2 PERIOD[15:0]
  - 3 BRIGHT[7:0]
  - 4 STATUS, read-only: bit0 = blink phase, bits[23:8] = prescaler value
  - 5–7 read 0; writes ignored
- **Width rules:** writes keep only the register's low bits and ignore upper `wdata` bits. Reads zero-extend to DATA_WIDTH.
- **Reset values:** DATA 0, MODE 0, PERIOD PERIOD_RST, BRIGHT 255, phase 1, prescaler 0, PWM counter 0, `out` 0, `ack` 0, `rdata` 0.
- **Bus FSM:**
  - States: IDLE, ACK.
  - IDLE with `sel`=1: perform the access at that edge and go to ACK.
  - ACK: `ack`=1 for exactly one cycle, then return to IDLE unconditionally.
  - `sel` still high in the IDLE cycle after ACK starts a new transfer. The master must drop `sel` after `ack` to avoid a duplicate transfer.
- **Step prescaler:**
  - 16-bit counter counts 0..PERIOD. Reaching PERIOD emits a one-cycle `step` and the counter returns to 0.
  - PERIOD=0 gives `step` every cycle.
  - Any write to PERIOD or MODE clears the counter and sets phase to 1.
- **Display value per mode:**
  - Static: display = DATA.
  - Blink: phase toggles on `step`; display = phase ? DATA : 0.
  - Rotate-left/right: DATA itself rotates by one bit within 9 bits on `step`; display = DATA. The rotated value is visible on readback.
- **Simultaneous CPU write to DATA and rotate `step`:** the write wins and that rotation is dropped.
- **PWM:**
  - 8-bit free-running counter that wraps 255→0.
  - BRIGHT=0 never lit. BRIGHT=255 always lit.
  - Otherwise lit when counter < BRIGHT.
- **Output:** `out` <= lit ? display : 0, registered.
- **Reset mid-transfer:** `ack` drops immediately, the FSM returns to IDLE, and the pending access is lost.

## Timing
- **Write:** `sel`&`we` sampled at edge E in IDLE.
  - Register updated at E.
  - `ack` high during E..E+1.
  - `out` reflects the new value from edge E+1.
- **Read:** `rdata` captured at E and presented with `ack` during E..E+1. It returns the register value before any same-edge `step` update.
- **Step cadence:**
  - With PERIOD=P, `step` fires every P+1 cycles.
  - The first `step` comes P+1 cycles after reset release or after a PERIOD/MODE write.
- **Latency:** `out` follows `step` and PWM changes with one cycle of latency.
- **Asynchronous reset:** all outputs go to their reset values as soon as `rst_n`=0, independent of `clk`.

## Test plan
- **Reset:** hold `rst_n`=0 with `clk` running → `out`=0, `ack`=0, `rdata`=0. Read PERIOD → 1000; read BRIGHT → 255.
- **Static write:** write DATA=0x1A5, MODE=0 → single-cycle `ack`; `out`=0x1A5 one cycle after the write edge. Read DATA → 0x000001A5. Write `wdata`=0xFFFFFFFF to DATA → reads 0x1FF.
- **Blink:** DATA=0x0FF, PERIOD=3, MODE=1 → `out` alternates 0x0FF/0x000 every 4 cycles, starting lit. STATUS bit0 tracks the phase.
- **Rotate-left:** DATA=0x100, PERIOD=0, MODE=2 → `out` sequence 0x001, 0x002, 0x004 …, one step per cycle. A write of DATA=0x003 coinciding with a step → next `out` is 0x003, not a rotated value.
- **PWM:** DATA=0x1FF, MODE=0, BRIGHT=64 → over 256 cycles `out`=0x1FF exactly 64 times. BRIGHT=0 → `out`=0 always. BRIGHT=255 → `out`=0x1FF always.
- **Handshake edges:** read `addr`=6 → `rdata`=0 with `ack`. Assert `rst_n`=0 in the ACK cycle → `ack` drops immediately and the register file returns to reset values.
